// File: rtl/montgomery_mul_ctrl_pkg.sv
// montgomery_mul_ctrl_pkg
//   Shared definitions for the Montgomery multiplier controller.
//   - state_t      : controller FSM states
//   - acc_width()  : width of the t + m*p accumulator for a given operand width
//   - DEFAULT_*    : default operand width and the matching accumulator width
package montgomery_mul_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MUL_T,
        MUL_M,
        MUL_U,
        FINAL,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 128;

    // t and m*p are both 2*width bits; their sum needs one extra carry bit.
    function automatic int acc_width(input int w);
        return 2 * w + 1;
    endfunction

    localparam int DEFAULT_ACC_WIDTH = acc_width(DEFAULT_WIDTH);

endpackage

// File: rtl/mont_cond_sub.sv
// mont_cond_sub
//   Final Montgomery reduction step: result = (u >= p) ? u - p : u.
//   u is known to be below 2p, so one conditional subtraction suffices.
//   Ports:
//     u      in  width+1  reduced accumulator (t + m*p) >> width
//     p      in  width    modulus
//     result out width    u mod p
module mont_cond_sub #(
    parameter int width = 128
) (
    input  logic [width:0]   u,
    input  logic [width-1:0] p,
    output logic [width-1:0] result
);

    logic             ge;
    logic [width-1:0] diff;

    // NOTE: every output of a combinational block is assigned on every path,
    // so no latch can be inferred.
    always_comb begin
        ge     = (u >= {1'b0, p});
        // Only the low width bits of u - p are needed: when ge holds the
        // true difference is below p and fits in width bits.
        diff   = u[width-1:0] - p;
        result = ge ? diff : u[width-1:0];
    end

endmodule

// File: rtl/montgomery_mul_ctrl.sv
// montgomery_mul_ctrl
//   Montgomery modular multiplier controller: result = a*b*2^(-width) mod p.
//   The three wide products (t = a*b, m = t*p_inv mod R, m*p) are requested
//   from an external multiplier over an enable/done handshake; the add,
//   shift and conditional subtraction are done here.
//   Ports:
//     clk, reset        clock, asynchronous active-low reset
//     start             request, sampled only when idle
//     a, b, p, p_inv    operands, odd modulus, -p^-1 mod 2^width
//     busy, done        in-progress flag, one-cycle completion pulse
//     result            Montgomery product, held until the next done
//     mul_enable        one-cycle multiplier request
//     mul_a, mul_b      multiplier operands, stable until mul_done
//     mul_ab, mul_done  2*width product and its one-cycle valid pulse
module montgomery_mul_ctrl
    import montgomery_mul_ctrl_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [width-1:0]     a,
    input  logic [width-1:0]     b,
    input  logic [width-1:0]     p,
    input  logic [width-1:0]     p_inv,
    output logic                 busy,
    output logic                 done,
    output logic [width-1:0]     result,
    output logic                 mul_enable,
    output logic [width-1:0]     mul_a,
    output logic [width-1:0]     mul_b,
    input  logic [2*width-1:0]   mul_ab,
    input  logic                 mul_done
);

    localparam int acc_w = acc_width(width);

    state_t               state;
    logic [width-1:0]     p_q;
    logic [width-1:0]     p_inv_q;
    logic [2*width-1:0]   t_q;
    logic [width:0]       u_q;

    logic [acc_w-1:0]     sum;
    logic [width-1:0]     sub_result;
    logic                 mul_ack;

    // mul_enable is high exactly in the first cycle of a MUL state, so a
    // mul_done arriving in that cycle (or outside a MUL state) is ignored.
    assign mul_ack = mul_done && !mul_enable;

    // s = t + m*p; the low width bits are zero by construction of m.
    assign sum = {1'b0, t_q} + {1'b0, mul_ab};

    mont_cond_sub #(
        .width (width)
    ) u_cond_sub (
        .u      (u_q),
        .p      (p_q),
        .result (sub_result)
    );

    // a and b need no private copies: they are loaded straight into the
    // mul_a/mul_b registers, which hold them for the whole first product.
    // NOTE: every register here, datapath included, is cleared by reset so
    // an aborted operation leaves no stale t/u/result behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            mul_enable <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            p_q        <= '0;
            p_inv_q    <= '0;
            t_q        <= '0;
            u_q        <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every right-hand side sees the pre-edge values.
            mul_enable <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        p_q        <= p;
                        p_inv_q    <= p_inv;
                        mul_a      <= a;
                        mul_b      <= b;
                        mul_enable <= 1'b1;
                        busy       <= 1'b1;
                        state      <= MUL_T;
                    end
                end

                MUL_T: begin
                    if (mul_ack) begin
                        t_q        <= mul_ab;
                        mul_a      <= mul_ab[width-1:0];
                        mul_b      <= p_inv_q;
                        mul_enable <= 1'b1;
                        state      <= MUL_M;
                    end
                end

                MUL_M: begin
                    // m = t*p_inv mod R: only the low half of the product.
                    if (mul_ack) begin
                        mul_a      <= mul_ab[width-1:0];
                        mul_b      <= p_q;
                        mul_enable <= 1'b1;
                        state      <= MUL_U;
                    end
                end

                MUL_U: begin
                    if (mul_ack) begin
                        u_q   <= sum[acc_w-1:width];
                        state <= FINAL;
                    end
                end

                FINAL: begin
                    result <= sub_result;
                    done   <= 1'b1;
                    state  <= DONE;
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
